// File: rtl/uart_tick_gen.sv
// uart_tick_gen: sample/bit-rate enable pulse generator for the UART path.
// Programmable divisor with glitch-free switching, count enable and phase re-sync.
module uart_tick_gen #(
  parameter  int DIV_W       = 16,
  parameter  int OSR         = 16,
  parameter  int DEFAULT_DIV = 326,
  localparam int OSR_W       = (OSR > 2) ? $clog2(OSR) : 1
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             smp_tick,
  output logic             bot_tick,
  output logic [OSR_W-1:0] smp_idx,
  output logic [DIV_W-1:0] div_cur,
  output logic             pend
);

  localparam logic [OSR_W-1:0] IDX_LAST = OSR_W'(OSR - 1);
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_pend;
  logic [DIV_W-1:0] div_new;
  logic             wrap;
  logic             last;
  logic             apply;

  // Period boundary, last sample of a bit, and the edges where a pending divisor may switch in.
  always_comb begin
    wrap    = (cnt == div_cur - DIV_ONE);
    last    = (smp_idx == IDX_LAST);
    apply   = pend & (sync | ~en | wrap);
    div_new = (div_in == '0) ? DIV_ONE : div_in;
  end

  // Cycle counter, sample index and the registered tick pulses.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cnt      <= '0;
      smp_idx  <= '0;
      smp_tick <= 1'b0;
      bot_tick <= 1'b0;
    end else if (sync) begin
      cnt      <= '0;
      smp_idx  <= '0;
      smp_tick <= 1'b0;
      bot_tick <= 1'b0;
    end else if (en) begin
      smp_tick <= wrap;
      bot_tick <= wrap & last;
      if (wrap) begin
        cnt     <= '0;
        smp_idx <= last ? '0 : smp_idx + OSR_W'(1);
      end else begin
        cnt <= cnt + DIV_ONE;
      end
    end else begin
      smp_tick <= 1'b0;
      bot_tick <= 1'b0;
    end
  end

  // Divisor staging: a new load only lands in div_cur at a period boundary,
  // a sync, or while disabled, so no period is ever cut short.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      div_cur  <= DIV_RST;
      div_pend <= '0;
      pend     <= 1'b0;
    end else begin
      if (apply) begin
        div_cur <= div_pend;
        pend    <= 1'b0;
      end
      if (div_load) begin
        div_pend <= div_new;
        pend     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tick_gen.sv
// tb_uart_tick_gen: scenario tasks plus randomized traffic
// against an integer reference model of the tick generator.
module tb_uart_tick_gen;

  localparam int DIV_W = 16;
  localparam int OSR   = 16;
  localparam int DEFD  = 326;
  localparam int OSR_W = 4;
  localparam int VW    = OSR_W + DIV_W + 3;

  logic             sys_clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic             sync = 1'b0;
  logic [DIV_W-1:0] div_in = '0;
  logic             div_load = 1'b0;
  logic             smp_tick;
  logic             bot_tick;
  logic [OSR_W-1:0] smp_idx;
  logic [DIV_W-1:0] div_cur;
  logic             pend;

  int vectors = 0;
  int miscompares = 0;

  int m_cnt, m_idx, m_div, m_dp;
  bit m_pend, m_smp, m_bot;

  logic [VW-1:0] dut_v;
  assign dut_v = {smp_tick, bot_tick, smp_idx, div_cur, pend};

  uart_tick_gen #(
    .DIV_W(DIV_W), .OSR(OSR), .DEFAULT_DIV(DEFD)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .en(en), .sync(sync),
    .div_in(div_in), .div_load(div_load),
    .smp_tick(smp_tick), .bot_tick(bot_tick), .smp_idx(smp_idx),
    .div_cur(div_cur), .pend(pend)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [VW-1:0] mod_v();
    return {m_smp, m_bot, OSR_W'(m_idx), DIV_W'(m_div), m_pend};
  endfunction

  // Reference: a period of m_div enabled cycles ends with a sample tick;
  // every OSR-th sample tick is a bit tick.
  task automatic model_edge();
    bit wrap;
    if (reset) begin
      m_cnt = 0; m_idx = 0; m_smp = 0; m_bot = 0;
      m_div = DEFD; m_pend = 0; m_dp = 0;
      return;
    end
    if (sync) begin
      m_cnt = 0; m_idx = 0; m_smp = 0; m_bot = 0;
      if (m_pend) begin m_div = m_dp; m_pend = 0; end
    end else if (en) begin
      wrap  = (m_cnt + 1 == m_div);
      m_smp = wrap;
      m_bot = wrap && ((m_idx + 1) % OSR == 0);
      m_cnt = wrap ? 0 : m_cnt + 1;
      if (wrap) begin
        m_idx = (m_idx + 1) % OSR;
        if (m_pend) begin m_div = m_dp; m_pend = 0; end
      end
    end else begin
      m_smp = 0; m_bot = 0;
      if (m_pend) begin m_div = m_dp; m_pend = 0; end
    end
    if (div_load) begin
      m_dp = (div_in == 0) ? 1 : int'(div_in);
      m_pend = 1;
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    int first_smp, second_smp, first_bot, idx_at_bot;
    first_smp = -1; second_smp = -1; first_bot = -1; idx_at_bot = -1;
    reset = 1; en = 1; step(); step();
    vectors++;
    if (dut_v !== {1'b0, 1'b0, 4'd0, 16'd326, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got %h exp %h", dut_v, {1'b0, 1'b0, 4'd0, 16'd326, 1'b0});
    end
    reset = 0;
    for (int i = 1; i <= 5216; i++) begin
      step();
      vectors++;
      if (dut_v !== mod_v()) begin
        miscompares++;
        $display("FAIL reset_run cyc %0d: got %h exp %h", i, dut_v, mod_v());
      end
      if (smp_tick && first_smp < 0) first_smp = i;
      else if (smp_tick && second_smp < 0) second_smp = i;
      if (bot_tick && first_bot < 0) begin
        first_bot = i; idx_at_bot = int'(smp_idx);
      end
    end
    vectors++;
    if (first_smp != 326 || second_smp != 652) begin
      miscompares++;
      $display("FAIL first_smp: got %0d,%0d exp 326,652", first_smp, second_smp);
    end
    vectors++;
    if (first_bot != 5216 || idx_at_bot != 0) begin
      miscompares++;
      $display("FAIL first_bot: got %0d idx %0d exp 5216 idx 0", first_bot, idx_at_bot);
    end
  endtask

  task automatic test_switch();
    reset = 1; step(); reset = 0;
    en = 0; div_load = 1; div_in = 10; step(); div_load = 0; step();
    vectors++;
    if (div_cur !== 16'd10 || pend !== 1'b0) begin
      miscompares++;
      $display("FAIL switch_setup: got div %0d pend %b exp 10 0", div_cur, pend);
    end
    en = 1;
    for (int i = 1; i <= 13; i++) begin
      step();
      vectors++;
      if (dut_v !== mod_v()) begin
        miscompares++;
        $display("FAIL switch_pre cyc %0d: got %h exp %h", i, dut_v, mod_v());
      end
    end
    div_load = 1; div_in = 4; step(); div_load = 0;
    vectors++;
    if (pend !== 1'b1 || div_cur !== 16'd10) begin
      miscompares++;
      $display("FAIL switch_pend: got pend %b div %0d exp 1 10", pend, div_cur);
    end
    for (int i = 1; i <= 14; i++) begin
      step();
      vectors++;
      if (smp_tick !== (i == 6 || i == 10 || i == 14)) begin
        miscompares++;
        $display("FAIL switch_tick cyc %0d: got %b exp %b", i, smp_tick, (i == 6 || i == 10 || i == 14));
      end
      if (i == 6) begin
        vectors++;
        if (div_cur !== 16'd4 || pend !== 1'b0) begin
          miscompares++;
          $display("FAIL switch_apply: got div %0d pend %b exp 4 0", div_cur, pend);
        end
      end
    end
  endtask

  task automatic test_div_zero();
    int ns, nb;
    ns = 0; nb = 0;
    en = 0; div_load = 1; div_in = 0; step(); div_load = 0;
    vectors++;
    if (pend !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_pend: got %b exp 1", pend);
    end
    step();
    vectors++;
    if (div_cur !== 16'd1 || pend !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_apply: got div %0d pend %b exp 1 0", div_cur, pend);
    end
    sync = 1; step(); sync = 0; en = 1;
    for (int i = 1; i <= 40; i++) begin
      step();
      ns += int'(smp_tick);
      nb += int'(bot_tick);
      vectors++;
      if (dut_v !== mod_v()) begin
        miscompares++;
        $display("FAIL zero_run cyc %0d: got %h exp %h", i, dut_v, mod_v());
      end
    end
    vectors++;
    if (ns != 40 || nb != 2) begin
      miscompares++;
      $display("FAIL zero_counts: got smp %0d bot %0d exp 40 2", ns, nb);
    end
  endtask

  task automatic test_double_load();
    int gap;
    gap = -1;
    en = 0; div_load = 1; div_in = 8; step(); div_load = 0; step();
    sync = 1; step(); sync = 0; en = 1;
    step(); step();
    div_load = 1; div_in = 7; step();
    div_in = 9; step(); div_load = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      vectors++;
      if (div_cur === 16'd7 || smp_tick !== (i == 4)) begin
        miscompares++;
        $display("FAIL dbl_tick cyc %0d: got div %0d smp %b exp div!=7 smp %b", i, div_cur, smp_tick, (i == 4));
      end
    end
    vectors++;
    if (div_cur !== 16'd9 || pend !== 1'b0) begin
      miscompares++;
      $display("FAIL dbl_apply: got div %0d pend %b exp 9 0", div_cur, pend);
    end
    en = 0; div_load = 1; div_in = 8; step(); div_load = 0; step();
    en = 1;
    repeat (5) step();
    sync = 1; step(); sync = 0;
    vectors++;
    if (smp_tick !== 1'b0 || bot_tick !== 1'b0 || smp_idx !== 4'd0) begin
      miscompares++;
      $display("FAIL sync_state: got %b%b idx %0d exp 00 idx 0", smp_tick, bot_tick, smp_idx);
    end
    for (int i = 1; i <= 20 && gap < 0; i++) begin
      step();
      if (smp_tick) gap = i;
    end
    vectors++;
    if (gap != 8) begin
      miscompares++;
      $display("FAIL sync_gap: got %0d exp 8", gap);
    end
  endtask

  task automatic test_pause();
    int gap;
    bit seen;
    gap = -1; seen = 0;
    sync = 1; step(); sync = 0;
    en = 1; step(); step();
    en = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (smp_tick || bot_tick) seen = 1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL pause_ticks: got tick exp none");
    end
    en = 1;
    for (int i = 23; i <= 40 && gap < 0; i++) begin
      step();
      if (smp_tick) gap = i;
    end
    vectors++;
    if (gap != 28) begin
      miscompares++;
      $display("FAIL pause_period: got %0d exp 28", gap);
    end
  endtask

  task automatic test_reset_mid();
    en = 1;
    repeat (13) step();
    reset = 1; div_load = 1; div_in = 5; sync = 1; step();
    reset = 0; div_load = 0; sync = 0;
    vectors++;
    if (dut_v !== {1'b0, 1'b0, 4'd0, 16'd326, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid: got %h exp %h", dut_v, {1'b0, 1'b0, 4'd0, 16'd326, 1'b0});
    end
    step();
    vectors++;
    if (dut_v !== mod_v() || pend !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_after: got %h exp %h", dut_v, mod_v());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom_range(0, 299) == 0);
      sync     = ($urandom_range(0, 59) == 0);
      en       = ($urandom_range(0, 99) < 85);
      div_load = ($urandom_range(0, 29) == 0);
      div_in   = DIV_W'($urandom_range(0, 12));
      step();
      vectors++;
      if (dut_v !== mod_v()) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %h exp %h", i, dut_v, mod_v());
      end
    end
    reset = 0; sync = 0; en = 0; div_load = 0;
  endtask

  initial begin
    test_reset();
    test_switch();
    test_div_zero();
    test_double_load();
    test_pause();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tick_gen.md
# uart_tick_gen

Parametrised baud/sample timing generator for the UART path of the single-cycle CPU system. It produces single-cycle enable pulses instead of divided, toggled clocks, so all downstream logic stays on `sys_clk`. It adds a runtime-programmable divisor with glitch-free switching, an enable, and a phase re-sync for receiver start-bit alignment. `smp_tick` drives the receiver sampler; `bot_tick` (one per `OSR` sample ticks) drives the bit/transmit timing.

## Interface

- `DIV_W`, 16: width of the divisor and the cycle counter.
- `OSR`, 16: sample ticks per bit tick; legal range 2..256.
- `DEFAULT_DIV`, 326: divisor loaded at reset (sys_clk cycles per sample tick); must be 1..2^DIV_W-1.
- Derived: `OSR_W` = max(1, clog2(OSR)).

- `sys_clk`  in  1  single system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; clears state on the next `sys_clk` edge.
- `en`  in  1  count enable; when low, counters hold and ticks are 0.
- `sync`  in  1  phase re-align; restarts both counters.
- `div_in`  in  DIV_W  new divisor value.
- `div_load`  in  1  one-cycle strobe that captures `div_in`.
- `smp_tick`  out  1  one-cycle sample-rate pulse.
- `bot_tick`  out  1  one-cycle bit-rate pulse; always coincides with a `smp_tick`.
- `smp_idx`  out  OSR_W  sample index within the current bit, 0..OSR-1.
- `div_cur`  out  DIV_W  divisor currently in effect.
- `pend`  out  1  a loaded divisor is waiting to be applied.

## Operation

- Internal state: `cnt` (DIV_W bits), `smp_idx`, `div_cur`, `div_pend` (DIV_W bits), `pend`, and the registered `smp_tick` and `bot_tick`.
- Edge priority, highest first: `reset`, `sync`, then `en`.
- `reset`:
  - `cnt`=0, `smp_idx`=0, `smp_tick`=0, `bot_tick`=0.
  - `div_cur`=DEFAULT_DIV, `pend`=0, `div_pend`=0.
  - A `div_load` on the same edge is discarded.
- `sync` (not reset):
  - `cnt`=0, `smp_idx`=0, both ticks 0.
  - If `pend`=1: `div_cur`<=`div_pend`, `pend`<=0.
  - Acts regardless of `en`.
- `en`=1, no `sync`:
  - If `cnt`==`div_cur`-1: `cnt`<=0 and `smp_tick`<=1 (this is a "wrap" edge).
  - Otherwise: `cnt`<=`cnt`+1 and `smp_tick`<=0.
  - On a wrap edge, if `smp_idx`==OSR-1: `smp_idx`<=0 and `bot_tick`<=1.
  - On a wrap edge otherwise: `smp_idx`<=`smp_idx`+1 and `bot_tick`<=0.
  - On a non-wrap edge, `bot_tick`<=0.
  - On a wrap edge with `pend`=1: `div_cur`<=`div_pend`, `pend`<=0; the new period starts with the next count.
- `en`=0, no `sync`:
  - `cnt` and `smp_idx` hold; both ticks <=0.
  - A pending divisor is applied immediately: `div_cur`<=`div_pend`, `pend`<=0.
- `div_load` (not reset):
  - `div_pend`<=`div_in`, `pend`<=1 on that edge; application follows the rules above from the next edge.
  - `div_in`=0 is stored as 1.
  - A load while `pend`=1 overwrites `div_pend`; only the last value is applied.
  - A load on the same edge as a wrap or `sync` is applied at the following wrap, `sync` or disabled edge, not on that edge.
- Divisor 1: `smp_tick` is high on every enabled cycle; `cnt` stays 0.
- No arithmetic overflow: `cnt` never exceeds `div_cur`-1.

## Timing

- All outputs are registered; no combinational input-to-output path.
- After `reset` deasserts, with `en`=1 and `div_cur`=N: `smp_tick` is first high in the cycle after the N-th enabled edge, then every N cycles.
- `bot_tick` is first high on the OSR-th `smp_tick`, then every OSR×N cycles.
- Pulse widths are exactly 1 cycle, including for N=1.
- `smp_idx` updates on the same edge that raises `smp_tick`, and reads 0 during a `bot_tick` cycle.
- `sync` at edge E: ticks are 0 after E; the first `smp_tick` follows edge E+N.
- Divisor change latency:
  - Enabled: at most one old period after the load.
  - Disabled: 1 cycle after the load.
  - No shortened or merged period is ever produced.
- `reset` mid-period takes effect on that edge; no tick is emitted on it.

## Test plan

- Reset, `en`=1, default divisor 326, OSR=16 -> first `smp_tick` after 326 cycles, period 326; `bot_tick` every 5216 cycles, coincident with `smp_idx` wrapping 15->0.
- Enabled at N=10: `div_load` with `div_in`=4 at cnt=3 -> `pend`=1; the remaining old period completes at 10 cycles; subsequent ticks every 4; `div_cur`=4 and `pend`=0 after the wrap.
- `div_in`=0 loaded with `en`=0 -> `div_cur`=1 one cycle later; re-enable -> `smp_tick` high every cycle, `bot_tick` every 16 cycles.
- Two loads (7 then 9) before a wrap -> 9 applied, never 7; `sync` at cnt=5 with N=8 -> next `smp_tick` after 8 edges, `smp_idx`=0.
- `en` dropped for 20 cycles at cnt=2 -> no ticks; count resumes from 2, so the period containing the pause is 20 cycles longer.
- `reset` asserted together with `div_load` and `sync` mid-operation -> all outputs at reset values, `div_cur`=326, `pend`=0.
